// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential Booth multiplier.
// MULT_UNSIGNED_EN adds a signed/unsigned mode and one extra Booth step.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned N_BITS = 32;

`ifdef MULT_UNSIGNED_EN
  localparam int unsigned EXT_BITS = 1;
`else
  localparam int unsigned EXT_BITS = 0;
`endif

  localparam int unsigned ITER  = N_BITS + EXT_BITS;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A,
// then arithmetic right shift of {A,Q,Q_1} by one bit.
module booth_step #(
  parameter int unsigned AW = 33,
  parameter int unsigned QW = 32
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] m,
  input  logic [QW-1:0] q,
  input  logic          q_1,
  output logic [AW-1:0] a_nx,
  output logic [QW-1:0] q_nx,
  output logic          q1_nx
);

  logic [AW-1:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    {a_nx, q_nx, q1_nx} = {sum[AW-1], sum, q};
  end

endmodule

// File: rtl/mult.sv
// Sequential radix-2 Booth multiplier writing a 2*n_bits product to hi/lo.
// Defining MULT_UNSIGNED_EN adds the multU port (unsigned when 1).
module mult
  import mult_pkg::*;
#(
  parameter int unsigned n_bits = N_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [n_bits-1:0] srcA,
  input  logic [n_bits-1:0] srcB,
`ifdef MULT_UNSIGNED_EN
  input  logic              multU,
`endif
  input  logic              multCtrl,
  output logic [n_bits-1:0] hi,
  output logic [n_bits-1:0] lo,
  output logic              multDone
);

  localparam int unsigned QW = n_bits + EXT_BITS;
  localparam int unsigned AW = QW + 1;
  localparam int unsigned CW = $clog2(QW + 1);

  state_t        state_q, state_d;
  logic [AW-1:0] a_q, a_d, m_q, m_d;
  logic [QW-1:0] q_q, q_d;
  logic          q1_q, q1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n_bits-1:0] hi_d, lo_d;
  logic          done_d;

  logic [QW-1:0] ext_a, ext_b;
  logic [AW-1:0] a_nx;
  logic [QW-1:0] q_nx;
  logic          q1_nx;
  logic [2*n_bits-1:0] prod_w;

`ifdef MULT_UNSIGNED_EN
  assign ext_a = {(multU ? 1'b0 : srcA[n_bits-1]), srcA};
  assign ext_b = {(multU ? 1'b0 : srcB[n_bits-1]), srcB};
`else
  assign ext_a = srcA;
  assign ext_b = srcB;
`endif

  // {A,Q} holds the full-width product; hi:lo keeps its low 2*n_bits bits.
  assign prod_w = (2*n_bits)'({a_q, q_q});

  booth_step #(.AW(AW), .QW(QW)) u_step (
    .a    (a_q),
    .m    (m_q),
    .q    (q_q),
    .q_1  (q1_q),
    .a_nx (a_nx),
    .q_nx (q_nx),
    .q1_nx(q1_nx)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi;
    lo_d    = lo;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (multCtrl) begin
          m_d     = {ext_a[QW-1], ext_a};
          a_d     = '0;
          q_d     = ext_b;
          q1_d    = 1'b0;
          cnt_d   = CW'(QW);
          state_d = RUN;
        end
      end
      RUN: begin
        // Steps run while the counter is nonzero; the edge that sees zero hands off to DONE.
        if (cnt_q != '0) begin
          a_d   = a_nx;
          q_d   = q_nx;
          q1_d  = q1_nx;
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        hi_d    = prod_w[2*n_bits-1:n_bits];
        lo_d    = prod_w[n_bits-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      multDone <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      m_q      <= m_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      hi       <= hi_d;
      lo       <= lo_d;
      multDone <= done_d;
    end
  end

endmodule

// File: doc/mult.md
Name: mult

Overview:
- Sequential radix-2 Booth multiplier for the multicycle CPU datapath; the counterpart of the iterative divider on the same HI/LO interface.
- Takes srcA/srcB plus a one-cycle multCtrl pulse from the control unit.
- Writes the 2·n_bits signed product into hi (upper half) and lo (lower half).
- One Booth step per clock; the control unit waits a fixed latency before reading HI/LO.

Parameters:
- n_bits, 32, operand width; hi and lo are each n_bits wide.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- srcA  input  n_bits  multiplicand (two's complement).
- srcB  input  n_bits  multiplier (two's complement).
- multCtrl  input  1  start pulse; sampled only in IDLE.
- hi  output  n_bits  product[2·n_bits-1:n_bits].
- lo  output  n_bits  product[n_bits-1:0].
- multDone  output  1  one-cycle pulse when hi/lo have just been updated.

Behaviour:
- Reset (any time, asynchronous): state=IDLE, hi=0, lo=0, multDone=0, counter=0, internal regs=0.
- States and transitions:
  - IDLE: on an edge with multCtrl=1, latch M={srcA[n-1],srcA} (n_bits+1 wide), A=0 (n_bits+1 wide), Q=srcB, Q_1=0, counter=n_bits; go to RUN.
  - RUN: each edge performs one Booth step on {Q[0],Q_1}:
    - 01 → A=A+M
    - 10 → A=A−M
    - 00/11 → no add
    - Then arithmetic right shift of {A,Q,Q_1} by one; counter−1.
    - On the edge where counter reaches 0, go to DONE.
  - DONE: one edge; hi=A[n_bits-1:0], lo=Q, multDone=1; go to IDLE. multDone returns to 0 on the next edge.
- Accumulator M/A is n_bits+1 wide so the most-negative multiplicand (−2^(n−1)) cannot overflow.
- Latency: multCtrl sampled at edge k → hi/lo valid and multDone=1 after edge k+n_bits+2 (34 for n_bits=32).
- hi/lo hold the previous result throughout RUN; they change only in DONE or on reset.
- multCtrl while in RUN/DONE: ignored; no queueing, no restart.
- srcA/srcB changes after the start edge have no effect; operands are latched.
- multCtrl held high continuously: a new operation starts on the first IDLE edge after DONE (back-to-back).
- Reset mid-operation: aborts immediately; hi/lo read 0; no multDone pulse.
- No overflow or zero flags; the full product always fits in hi:lo.

Optional Feature:
- Macro: MULT_UNSIGNED_EN.
- With the macro defined:
  - Adds input port multU (1 bit), latched with the operands.
  - Operands are extended to n_bits+1 bits: zero-extended when multU=1, sign-extended when multU=0.
  - Accumulator is n_bits+2 wide; n_bits+1 Booth steps in both modes.
  - Latency becomes n_bits+3 edges.
  - hi/lo take the low 2·n_bits bits of the product.
- Without the macro: no multU port; signed only; latency n_bits+2.

Decomposition:
- Package mult_pkg:
  - state typedef {IDLE, RUN, DONE}
  - default N_BITS=32
  - localparams ITER (n_bits, or n_bits+1 under the macro) and CNT_W=$clog2(ITER+1)
- One sub-module: booth_step.
  - Combinational: inputs A, M, Q, Q_1; outputs the next {A,Q,Q_1}.
  - Instantiated once in mult; the sequential control stays in mult.

Test Plan:
- Reset held 2 cycles, then released → hi=0, lo=0, multDone=0, state IDLE.
- srcA=−24, srcB=6, 1-cycle multCtrl → after 34 edges hi=0xFFFFFFFF, lo=0xFFFFFF70, multDone pulses exactly once.
- srcA=190, srcB=13 → hi=0x00000000, lo=0x000009A6.
- srcA=0x80000000, srcB=0x80000000 → hi=0x40000000, lo=0x00000000.
- srcA=0x7FFFFFFF, srcB=0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001.
- Re-pulse multCtrl with new operands during RUN → ignored; first result unchanged.
- Assert reset at cycle 10 of RUN → hi=lo=0 immediately, no multDone.
- With MULT_UNSIGNED_EN, srcA=srcB=0xFFFFFFFF:
  - multU=1 → hi=0xFFFFFFFE, lo=0x00000001.
  - multU=0 → hi=0, lo=1.
  - Both with latency 35 edges.
